// File: rtl/spi_bist_checker.sv
// SPI BIST loopback checker: deserialises MOSI/MISO per CS-low frame,
// compares against expected bytes, keeps saturating counters and a sticky fail.
//
// Ports:
//   clk, reset (async, active-low), clear (sync pulse)
//   CS, S_clk, MOSI_res, MISO_res : serial loopback inputs (async to clk)
//   exp_mosi, exp_miso            : expected bytes, latched at CS fall
//   done, pass, frame_err         : per-frame result (done is a 1-clk pulse)
//   mosi_byte, miso_byte          : last captured bytes
//   frame_count, error_count      : saturating counters
//   sticky_fail, busy             : sign-off flag, activity flag
module spi_bist_checker #(
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_RISE = 1,
  parameter int MSB_FIRST   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              CS,
  input  logic              S_clk,
  input  logic              MOSI_res,
  input  logic              MISO_res,
  input  logic [DATA_W-1:0] exp_mosi,
  input  logic [DATA_W-1:0] exp_miso,
  output logic              done,
  output logic              pass,
  output logic              frame_err,
  output logic [DATA_W-1:0] mosi_byte,
  output logic [DATA_W-1:0] miso_byte,
  output logic [CNT_W-1:0]  frame_count,
  output logic [CNT_W-1:0]  error_count,
  output logic              sticky_fail,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] FULL = BW'(DATA_W);
  localparam logic [CNT_W-1:0] CMAX = '1;
  // bit order {miso, mosi, sclk, cs}; CS idles high
  localparam logic [3:0] SYNC_RST = 4'b0001;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t state, next;

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] dly_q;

  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] sh_mosi, sh_miso;
  logic [DATA_W-1:0] exp_m_q, exp_s_q;

  logic cs_s, cs_d, sclk_s, sclk_d, mosi_s, miso_s;
  logic cs_fall, sclk_edge, take, finish, pass_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= SYNC_RST;
      dly_q <= SYNC_RST;
    end else begin
      sync_q[0] <= {MISO_res, MOSI_res, S_clk, CS};
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cs_s   = sync_q[SYNC_STAGES-1][0];
  assign sclk_s = sync_q[SYNC_STAGES-1][1];
  assign mosi_s = sync_q[SYNC_STAGES-1][2];
  assign miso_s = sync_q[SYNC_STAGES-1][3];
  assign cs_d   = dly_q[0];
  assign sclk_d = dly_q[1];

  assign cs_fall   = cs_d & ~cs_s;
  assign sclk_edge = (SAMPLE_RISE != 0) ? (sclk_s & ~sclk_d)
                                        : (~sclk_s & sclk_d);

  // Gating on the delayed CS lets a bit arriving with the CS rise count.
  assign take   = (state == SHIFT) && sclk_edge && !cs_d
                  && (bit_cnt < FULL);
  assign finish = (state == SHIFT) && (next == CHECK);

  assign pass_nx = (sh_mosi == exp_m_q) && (sh_miso == exp_s_q)
                   && (bit_cnt == FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (cs_fall) next = SHIFT;
      SHIFT:   if (bit_cnt == FULL || cs_d) next = CHECK;
      CHECK:   next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    done = (state == CHECK);
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      sh_mosi <= '0;
      sh_miso <= '0;
      exp_m_q <= '0;
      exp_s_q <= '0;
    end else if (state == IDLE && cs_fall) begin
      bit_cnt <= '0;
      sh_mosi <= '0;
      sh_miso <= '0;
      exp_m_q <= exp_mosi;
      exp_s_q <= exp_miso;
    end else if (take) begin
      bit_cnt <= bit_cnt + 1'b1;
      if (MSB_FIRST != 0) begin
        sh_mosi <= {sh_mosi[DATA_W-2:0], mosi_s};
        sh_miso <= {sh_miso[DATA_W-2:0], miso_s};
      end else begin
        sh_mosi <= {mosi_s, sh_mosi[DATA_W-1:1]};
        sh_miso <= {miso_s, sh_miso[DATA_W-1:1]};
      end
    end
  end

  // Results load on CHECK entry so they are valid while done is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass      <= 1'b0;
      frame_err <= 1'b0;
    end else if (finish) begin
      pass      <= pass_nx;
      frame_err <= (bit_cnt != FULL);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mosi_byte <= '0;
      miso_byte <= '0;
    end else if (clear) begin
      mosi_byte <= '0;
      miso_byte <= '0;
    end else if (finish) begin
      mosi_byte <= sh_mosi;
      miso_byte <= sh_miso;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
      error_count <= '0;
      sticky_fail <= 1'b0;
    end else if (clear) begin
      frame_count <= '0;
      error_count <= '0;
      sticky_fail <= 1'b0;
    end else if (state == CHECK) begin
      if (frame_count != CMAX) frame_count <= frame_count + 1'b1;
      if (!pass) begin
        if (error_count != CMAX) error_count <= error_count + 1'b1;
        sticky_fail <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_bist_checker.sv
// Directed bench for spi_bist_checker: one task per scenario,
// inline comparisons against hand-computed values.
module tb_spi_bist_checker;

  localparam int HP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       CS = 1'b1;
  logic       S_clk = 1'b0;
  logic       MOSI_res = 1'b0;
  logic       MISO_res = 1'b0;
  logic [7:0] exp_mosi = 8'h00;
  logic [7:0] exp_miso = 8'h00;
  logic       done, pass, frame_err, sticky_fail, busy;
  logic [7:0] mosi_byte, miso_byte, frame_count, error_count;

  int n = 0;
  int f = 0;
  int done_cnt = 0;
  int cyc = 0;
  int done_cyc = 0;
  int t_last = 0;
  logic       cp_pass, cp_ferr;
  logic [7:0] cp_mosi, cp_miso;

  spi_bist_checker dut (
    .clk(clk), .reset(rst_n), .clear(clear),
    .CS(CS), .S_clk(S_clk),
    .MOSI_res(MOSI_res), .MISO_res(MISO_res),
    .exp_mosi(exp_mosi), .exp_miso(exp_miso),
    .done(done), .pass(pass), .frame_err(frame_err),
    .mosi_byte(mosi_byte), .miso_byte(miso_byte),
    .frame_count(frame_count), .error_count(error_count),
    .sticky_fail(sticky_fail), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      cp_pass = pass;
      cp_ferr = frame_err;
      cp_mosi = mosi_byte;
      cp_miso = miso_byte;
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic spi_frame(input logic [7:0] m, input logic [7:0] s,
                           input int nbits);
    CS = 1'b0;
    tick(2*HP);
    for (int i = 0; i < nbits; i++) begin
      if (i < 8) begin
        MOSI_res = m[7-i];
        MISO_res = s[7-i];
      end else begin
        MOSI_res = 1'b1;
        MISO_res = 1'b1;
      end
      tick(HP);
      S_clk = 1'b1;
      t_last = cyc;
      tick(HP);
      S_clk = 1'b0;
    end
    tick(HP);
    CS = 1'b1;
    tick(3*HP + 6);
  endtask

  task automatic test_reset;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    n++; if (done !== 1'b0) begin f++; $display("FAIL rst_done got %b exp 0", done); end
    n++; if (pass !== 1'b0) begin f++; $display("FAIL rst_pass got %b exp 0", pass); end
    n++; if (frame_err !== 1'b0) begin f++; $display("FAIL rst_ferr got %b exp 0", frame_err); end
    n++; if (mosi_byte !== 8'h00) begin f++; $display("FAIL rst_mosi got %h exp 00", mosi_byte); end
    n++; if (frame_count !== 8'h00) begin f++; $display("FAIL rst_fc got %h exp 00", frame_count); end
    n++; if (error_count !== 8'h00) begin f++; $display("FAIL rst_ec got %h exp 00", error_count); end
    n++; if (sticky_fail !== 1'b0) begin f++; $display("FAIL rst_sticky got %b exp 0", sticky_fail); end
    n++; if (busy !== 1'b0) begin f++; $display("FAIL rst_busy got %b exp 0", busy); end
  endtask

  task automatic test_good_frame;
    int d0;
    d0 = done_cnt;
    exp_mosi = 8'hF0; exp_miso = 8'hF0;
    spi_frame(8'hF0, 8'hF0, 8);
    n++; if (done_cnt - d0 !== 1) begin f++; $display("FAIL t1_done got %0d exp 1", done_cnt - d0); end
    n++; if (done_cyc - t_last !== 5) begin f++; $display("FAIL t1_latency got %0d exp 5", done_cyc - t_last); end
    n++; if (cp_pass !== 1'b1) begin f++; $display("FAIL t1_pass got %b exp 1", cp_pass); end
    n++; if (cp_mosi !== 8'hF0) begin f++; $display("FAIL t1_mosi got %h exp F0", cp_mosi); end
    n++; if (cp_miso !== 8'hF0) begin f++; $display("FAIL t1_miso got %h exp F0", cp_miso); end
    n++; if (frame_count !== 8'd1) begin f++; $display("FAIL t1_fc got %h exp 01", frame_count); end
    n++; if (error_count !== 8'd0) begin f++; $display("FAIL t1_ec got %h exp 00", error_count); end
  endtask

  task automatic test_mismatch;
    spi_frame(8'hF1, 8'hF0, 8);
    n++; if (cp_pass !== 1'b0) begin f++; $display("FAIL t2_pass got %b exp 0", cp_pass); end
    n++; if (cp_mosi !== 8'hF1) begin f++; $display("FAIL t2_mosi got %h exp F1", cp_mosi); end
    n++; if (cp_ferr !== 1'b0) begin f++; $display("FAIL t2_ferr got %b exp 0", cp_ferr); end
    n++; if (error_count !== 8'd1) begin f++; $display("FAIL t2_ec got %h exp 01", error_count); end
    n++; if (sticky_fail !== 1'b1) begin f++; $display("FAIL t2_sticky got %b exp 1", sticky_fail); end
  endtask

  task automatic test_short_frame;
    int d0;
    d0 = done_cnt;
    spi_frame(8'hF0, 8'hF0, 5);
    n++; if (done_cnt - d0 !== 1) begin f++; $display("FAIL t3_done got %0d exp 1", done_cnt - d0); end
    n++; if (cp_ferr !== 1'b1) begin f++; $display("FAIL t3_ferr got %b exp 1", cp_ferr); end
    n++; if (cp_pass !== 1'b0) begin f++; $display("FAIL t3_pass got %b exp 0", cp_pass); end
    n++; if (cp_mosi !== 8'h1E) begin f++; $display("FAIL t3_mosi got %h exp 1E", cp_mosi); end
    n++; if (error_count !== 8'd2) begin f++; $display("FAIL t3_ec got %h exp 02", error_count); end
  endtask

  task automatic test_extra_edges;
    int d0;
    d0 = done_cnt;
    spi_frame(8'hF0, 8'hF0, 12);
    n++; if (done_cnt - d0 !== 1) begin f++; $display("FAIL t4_done got %0d exp 1", done_cnt - d0); end
    n++; if (cp_mosi !== 8'hF0) begin f++; $display("FAIL t4_mosi got %h exp F0", cp_mosi); end
    n++; if (cp_miso !== 8'hF0) begin f++; $display("FAIL t4_miso got %h exp F0", cp_miso); end
    n++; if (cp_pass !== 1'b1) begin f++; $display("FAIL t4_pass got %b exp 1", cp_pass); end
    n++; if (frame_count !== 8'd4) begin f++; $display("FAIL t4_fc got %h exp 04", frame_count); end
  endtask

  task automatic test_saturate_clear;
    for (int i = 0; i < 256; i++)
      spi_frame(8'hF0, 8'hF0, 8);
    n++; if (frame_count !== 8'hFF) begin f++; $display("FAIL t5_fc got %h exp FF", frame_count); end
    n++; if (error_count !== 8'd2) begin f++; $display("FAIL t5_ec got %h exp 02", error_count); end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
    n++; if (frame_count !== 8'h00) begin f++; $display("FAIL t5_clr_fc got %h exp 00", frame_count); end
    n++; if (error_count !== 8'h00) begin f++; $display("FAIL t5_clr_ec got %h exp 00", error_count); end
    n++; if (sticky_fail !== 1'b0) begin f++; $display("FAIL t5_clr_sticky got %b exp 0", sticky_fail); end
    n++; if (mosi_byte !== 8'h00) begin f++; $display("FAIL t5_clr_mosi got %h exp 00", mosi_byte); end
  endtask

  task automatic test_reset_midframe;
    int d0;
    d0 = done_cnt;
    CS = 1'b0;
    tick(2*HP);
    for (int i = 0; i < 3; i++) begin
      MOSI_res = 1'b1; MISO_res = 1'b1;
      tick(HP);
      S_clk = 1'b1;
      tick(HP);
      S_clk = 1'b0;
    end
    rst_n = 1'b0;
    CS = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    n++; if (done_cnt - d0 !== 0) begin f++; $display("FAIL t6_abort_done got %0d exp 0", done_cnt - d0); end
    n++; if (busy !== 1'b0) begin f++; $display("FAIL t6_busy got %b exp 0", busy); end
    spi_frame(8'hF0, 8'hF0, 8);
    n++; if (done_cnt - d0 !== 1) begin f++; $display("FAIL t6_done got %0d exp 1", done_cnt - d0); end
    n++; if (cp_pass !== 1'b1) begin f++; $display("FAIL t6_pass got %b exp 1", cp_pass); end
    n++; if (frame_count !== 8'd1) begin f++; $display("FAIL t6_fc got %h exp 01", frame_count); end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_mismatch;
    test_short_frame;
    test_extra_edges;
    test_saturate_clear;
    test_reset_midframe;
    $display("%0d/%0d checks passed", n - f, n);
    $finish;
  end

endmodule
